// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
//   rseq_state_t : sequencer FSM states
//   CNT_SAT      : saturation value of the 8-bit status counters
//   sat_inc      : increment that sticks at CNT_SAT
package reset_seq_pkg;

  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN} rseq_state_t;

  localparam logic [7:0] CNT_SAT = 8'hFF;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == CNT_SAT) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lock_synchronizer.sv
// Multi-flop synchronizer that brings the asynchronous PLL lock into clk.
//   clk      : sampling clock
//   reset    : synchronous, active-high; clears the chain to 0
//   async_in : asynchronous input
//   sync_out : synchronized output, DEPTH edges behind async_in
module lock_synchronizer #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  (* ASYNC_REG = "TRUE" *) logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], async_in};
  end

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign sync_out = sync_q[DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// PLL reset / lock qualification and staggered per-domain reset release.
//   clk             : free-running reference clock (PLL input clock)
//   reset           : synchronous, active-high
//   pll_locked      : PLL lock, asynchronous to clk
//   pll_reset       : reset to the PLL
//   rst_out         : per-domain resets, active-high, stage 0 released first
//   all_ready       : every rst_out bit is low
//   retry_count     : lock timeouts since reset, saturating
//   lock_loss_count : lock losses after release began, saturating
//
// state     | meaning
// ----------+---------------------------------------------------------
// PLL_RST   | pll_reset held high for PLL_RST_CYCLES
// WAIT_LOCK | waiting for synchronized lock, retry PLL after timeout
// STABLE    | lock seen, qualifying for LOCK_STABLE consecutive cycles
// RELEASE   | dropping one stage every STAGE_GAP cycles
// RUN       | all stages released, watching for lock loss
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES     = 3,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 250000,
  parameter int LOCK_STABLE    = 2500,   // >= 2: the WAIT_LOCK cycle that sees lock counts as the first
  parameter int STAGE_GAP      = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pll_locked,
  output logic                  pll_reset,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  all_ready,
  output logic [7:0]            retry_count,
  output logic [7:0]            lock_loss_count
);

  localparam int MAX_AB  = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
  localparam int MAX_CD  = (STAGE_GAP > PLL_RST_CYCLES) ? STAGE_GAP : PLL_RST_CYCLES;
  localparam int CYC_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int STG_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CYC_W-1:0] PLL_RST_LAST = CYC_W'(PLL_RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT - 1);
  localparam logic [CYC_W-1:0] STABLE_LAST  = CYC_W'(LOCK_STABLE - 2);
  localparam logic [CYC_W-1:0] GAP_LAST     = CYC_W'(STAGE_GAP - 1);
  localparam logic [STG_W-1:0] LAST_STAGE   = STG_W'(NUM_STAGES - 1);

  rseq_state_t           state_q, state_d;
  logic [CYC_W-1:0]      cyc_q, cyc_d;
  logic [STG_W-1:0]      stage_q, stage_d;
  logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
  logic                  all_ready_q, all_ready_d;
  logic                  pll_reset_q, pll_reset_d;
  logic [7:0]            retry_q, retry_d;
  logic [7:0]            loss_q, loss_d;
  logic                  lock_s;

  lock_synchronizer #(.DEPTH(2)) u_lock_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (pll_locked),
    .sync_out (lock_s)
  );

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q + 1'b1;
    stage_d   = stage_q;
    rst_out_d = rst_out_q;
    retry_d   = retry_q;
    loss_d    = loss_q;

    case (state_q)
      PLL_RST: begin
        if (cyc_q == PLL_RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // lock takes priority over a simultaneous timeout
        if (lock_s) begin
          state_d = STABLE;
        end else if (cyc_q == TIMEOUT_LAST) begin
          state_d = PLL_RST;
          retry_d = sat_inc(retry_q);
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (cyc_q == STABLE_LAST) begin
          state_d      = RELEASE;
          stage_d      = '0;
          rst_out_d[0] = 1'b0;
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_d   = WAIT_LOCK;
          rst_out_d = '1;
          loss_d    = sat_inc(loss_q);
        end else if (stage_q == LAST_STAGE) begin
          state_d = RUN;
        end else if (cyc_q == GAP_LAST) begin
          // the gap timer is restarted per stage without leaving RELEASE
          stage_d            = stage_q + 1'b1;
          rst_out_d[stage_d] = 1'b0;
          cyc_d              = '0;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d   = WAIT_LOCK;
          rst_out_d = '1;
          loss_d    = sat_inc(loss_q);
        end
      end
      default: begin
        state_d   = PLL_RST;
        rst_out_d = '1;
      end
    endcase

    if (state_d != state_q) cyc_d = '0;

    pll_reset_d = (state_d == PLL_RST);
    all_ready_d = ~|rst_out_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PLL_RST;
      cyc_q       <= '0;
      stage_q     <= '0;
      rst_out_q   <= '1;
      all_ready_q <= 1'b0;
      pll_reset_q <= 1'b1;
      retry_q     <= '0;
      loss_q      <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stage_q     <= stage_d;
      rst_out_q   <= rst_out_d;
      all_ready_q <= all_ready_d;
      pll_reset_q <= pll_reset_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
    end
  end

  assign pll_reset       = pll_reset_q;
  assign rst_out         = rst_out_q;
  assign all_ready       = all_ready_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with small timing parameters.
module tb_reset_sequencer;

  localparam int NUM_STAGES     = 3;
  localparam int PLL_RST_CYCLES = 4;
  localparam int LOCK_TIMEOUT   = 100;
  localparam int LOCK_STABLE    = 16;
  localparam int STAGE_GAP      = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_reset;
  logic [2:0] rst_out;
  logic       all_ready;
  logic [7:0] retry_count;
  logic [7:0] lock_loss_count;

  int n_checks = 0;
  int n_errors = 0;

  reset_sequencer #(
    .NUM_STAGES     (NUM_STAGES),
    .PLL_RST_CYCLES (PLL_RST_CYCLES),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT),
    .LOCK_STABLE    (LOCK_STABLE),
    .STAGE_GAP      (STAGE_GAP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pll_locked      (pll_locked),
    .pll_reset       (pll_reset),
    .rst_out         (rst_out),
    .all_ready       (all_ready),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic sig_of(input int sel);
    case (sel)
      0:       return pll_reset;
      1:       return rst_out[0];
      2:       return rst_out[1];
      3:       return rst_out[2];
      default: return all_ready;
    endcase
  endfunction

  // edges until the selected signal shows val (sampled 1 unit after each edge); -1 on timeout
  task automatic wait_for(input int sel, input logic val, output int n);
    bit found;
    found = 0;
    n = -1;
    for (int i = 1; i <= 2000 && !found; i++) begin
      @(posedge clk);
      #1;
      if (sig_of(sel) === val) begin
        n = i;
        found = 1;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // called right after pll_locked rises (1 unit after an edge)
  task automatic check_release(input string tag);
    int n;
    wait_for(1, 1'b0, n);
    check({tag, "_rst0_edges"}, n, 18);
    check({tag, "_rst0_vec"}, rst_out, 3'b110);
    wait_for(2, 1'b0, n);
    check({tag, "_rst1_gap"}, n, 8);
    check({tag, "_rst1_vec"}, rst_out, 3'b100);
    check({tag, "_rdy_early"}, all_ready, 1'b0);
    wait_for(3, 1'b0, n);
    check({tag, "_rst2_gap"}, n, 8);
    check({tag, "_rst2_vec"}, rst_out, 3'b000);
    check({tag, "_rdy"}, all_ready, 1'b1);
  endtask

  initial begin
    int n;

    // 1. nominal
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_pll_reset", pll_reset, 1'b1);
    check("rst_rst_out", rst_out, 3'b111);
    check("rst_all_ready", all_ready, 1'b0);
    check("rst_retry", retry_count, 0);
    check("rst_loss", lock_loss_count, 0);
    reset = 1'b0;
    wait_for(0, 1'b0, n);
    check("nom_pll_rst_len", n, 4);
    repeat (20) @(posedge clk);
    #1;
    pll_locked = 1'b1;
    check_release("nom");
    repeat (5) @(posedge clk);
    #1;
    check("nom_run_ready", all_ready, 1'b1);

    // 4. lock loss in RUN, then relock
    pll_locked = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("run_loss_e2_vec", rst_out, 3'b000);
    check("run_loss_e2_rdy", all_ready, 1'b1);
    @(posedge clk);
    #1;
    check("run_loss_e3_vec", rst_out, 3'b111);
    check("run_loss_e3_rdy", all_ready, 1'b0);
    check("run_loss_cnt", lock_loss_count, 1);
    check("run_loss_pllrst", pll_reset, 1'b0);
    pll_locked = 1'b1;
    check_release("relock");

    // 5. lock loss mid-RELEASE
    pll_locked = 1'b0;
    do_reset();
    wait_for(0, 1'b0, n);
    check("mid_pll_rst_len", n, 4);
    repeat (20) @(posedge clk);
    #1;
    pll_locked = 1'b1;
    wait_for(1, 1'b0, n);
    check("mid_rst0_edges", n, 18);
    repeat (2) @(posedge clk);
    #1;
    pll_locked = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_e2_vec", rst_out, 3'b110);
    @(posedge clk);
    #1;
    check("mid_e3_vec", rst_out, 3'b111);
    check("mid_loss_cnt", lock_loss_count, 1);
    pll_locked = 1'b1;
    check_release("mid_relock");

    // 6. reset during STABLE
    pll_locked = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pll_locked = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("stb_loss_pre", lock_loss_count, 2);
    check("stb_vec_pre", rst_out, 3'b111);
    reset = 1'b1;
    pll_locked = 1'b0;
    @(posedge clk);
    #1;
    check("stb_rst_pll", pll_reset, 1'b1);
    check("stb_rst_loss", lock_loss_count, 0);
    check("stb_rst_retry", retry_count, 0);
    check("stb_rst_vec", rst_out, 3'b111);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_for(0, 1'b0, n);
    check("stb_pll_rst_len", n, 4);

    // 3. glitchy lock
    repeat (20) @(posedge clk);
    #1;
    pll_locked = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    pll_locked = 1'b0;
    @(posedge clk);
    #1;
    pll_locked = 1'b1;
    wait_for(1, 1'b0, n);
    check("glitch_rst0_edges", n, 18);
    check("glitch_retry", retry_count, 0);
    check("glitch_loss", lock_loss_count, 0);

    // 2. timeout and saturation
    pll_locked = 1'b0;
    do_reset();
    wait_for(0, 1'b0, n);
    check("to_pll_rst_len", n, 4);
    for (int k = 1; k <= 3; k++) begin
      wait_for(0, 1'b1, n);
      check("to_wait_len", n, 100);
      check("to_retry", retry_count, k);
      wait_for(0, 1'b0, n);
      check("to_pulse_len", n, 4);
    end
    repeat (253 * 104) @(posedge clk);
    #1;
    check("to_retry_sat", retry_count, 255);
    check("to_loss", lock_loss_count, 0);
    check("to_vec", rst_out, 3'b111);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
